price_level_book: RTL and testbench

PRICE_LEVEL_BOOK -- requirements
Module: price_level_book

---
 rtl/price_level_book.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_price_level_book.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/price_level_book.sv
// Price-level order book. Each side keeps up to DEPTH sorted levels, and level 0 is the best.
// Requests move through IDLE -> SEARCH -> APPLY: one request every 3 cycles, with a pulse 2 cycles after accept.
module price_level_book #(
  parameter int DEPTH   = 10,
  parameter int PRICE_W = 64,
  parameter int QTY_W   = 16,
  parameter int NORD_W  = 8,
  localparam int LVL_W  = QTY_W + NORD_W + PRICE_W,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_action,
  input  logic                     in_side,
  input  logic [PRICE_W-1:0]       in_price,
  input  logic [QTY_W-1:0]         in_qty,
  input  logic [NORD_W-1:0]        in_norders,
  output logic [DEPTH*LVL_W-1:0]   bid_book,
  output logic [DEPTH*LVL_W-1:0]   ask_book,
  output logic [CNT_W-1:0]         bid_count,
  output logic [CNT_W-1:0]         ask_count,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_level,
  output logic [1:0]               err
);

  localparam logic [1:0] ACT_NEW = 2'd0, ACT_CHG = 2'd1, ACT_DEL = 2'd2, ACT_CLR = 2'd3;
  localparam logic [1:0] ERR_OK = 2'd0, ERR_NOMATCH = 2'd1, ERR_DROP = 2'd2, ERR_SAT = 2'd3;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEARCH = 2'd1, ST_APPLY = 2'd2} state_t;

  function automatic logic [PRICE_W-1:0] lvl_price(input logic [LVL_W-1:0] l);
    return l[PRICE_W-1:0];
  endfunction

  function automatic logic [NORD_W-1:0] lvl_nord(input logic [LVL_W-1:0] l);
    return l[PRICE_W +: NORD_W];
  endfunction

  function automatic logic [QTY_W-1:0] lvl_qty(input logic [LVL_W-1:0] l);
    return l[PRICE_W+NORD_W +: QTY_W];
  endfunction

  state_t                   state_q, state_d;
  logic [1:0]               act_q, act_d;
  logic                     side_q, side_d;
  logic [PRICE_W-1:0]       price_q, price_d;
  logic [QTY_W-1:0]         qty_q, qty_d;
  logic [NORD_W-1:0]        nord_q, nord_d;
  logic                     match_q, match_d;
  logic [IDX_W-1:0]         match_idx_q, match_idx_d;
  logic [CNT_W-1:0]         ins_idx_q, ins_idx_d;
  logic [DEPTH*LVL_W-1:0]   bid_q, bid_d, ask_q, ask_d;
  logic [CNT_W-1:0]         bid_cnt_q, bid_cnt_d, ask_cnt_q, ask_cnt_d;
  logic                     upd_valid_q, upd_valid_d;
  logic [IDX_W-1:0]         upd_level_q, upd_level_d;
  logic [1:0]               err_q, err_d;

  logic [LVL_W-1:0]         cur [DEPTH];
  logic [LVL_W-1:0]         nxt [DEPTH];
  logic [CNT_W-1:0]         cur_cnt, nxt_cnt;
  logic                     srch_match, ins_found, hit_m, hit_w;
  logic [IDX_W-1:0]         srch_midx;
  logic [CNT_W-1:0]         srch_ins;
  logic [QTY_W:0]           qsum;
  logic [NORD_W:0]          nsum;
  logic [QTY_W-1:0]         qty_sat;
  logic [NORD_W-1:0]        nord_sat;
  logic                     do_del;
  logic [1:0]               app_err;
  logic [IDX_W-1:0]         app_lvl;

  // View of the side addressed by the registered request.
  always_comb begin
    cur_cnt = side_q ? ask_cnt_q : bid_cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      cur[i] = side_q ? ask_q[i*LVL_W +: LVL_W] : bid_q[i*LVL_W +: LVL_W];
    end
  end

  // Match and insert-point search over the valid levels. A level is worse when it is a lower bid or a higher ask.
  always_comb begin
    srch_match = 1'b0;
    srch_midx  = '0;
    srch_ins   = cur_cnt;
    ins_found  = 1'b0;
    hit_m      = 1'b0;
    hit_w      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_m = (CNT_W'(i) < cur_cnt) && (lvl_price(cur[i]) == price_q);
      hit_w = (CNT_W'(i) < cur_cnt) &&
              (side_q ? (lvl_price(cur[i]) > price_q) : (lvl_price(cur[i]) < price_q));
      srch_midx  = (hit_m && !srch_match) ? IDX_W'(i) : srch_midx;
      srch_ins   = (hit_w && !ins_found) ? CNT_W'(i) : srch_ins;
      srch_match = srch_match | hit_m;
      ins_found  = ins_found | hit_w;
    end
  end

  // Next contents of the addressed side for the registered request.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = cur[i];
    end
    nxt_cnt  = cur_cnt;
    app_err  = ERR_OK;
    app_lvl  = '0;
    do_del   = 1'b0;
    qsum     = {1'b0, lvl_qty(cur[match_idx_q])} + {1'b0, qty_q};
    nsum     = {1'b0, lvl_nord(cur[match_idx_q])} + {1'b0, nord_q};
    qty_sat  = qsum[QTY_W] ? {QTY_W{1'b1}} : qsum[QTY_W-1:0];
    nord_sat = nsum[NORD_W] ? {NORD_W{1'b1}} : nsum[NORD_W-1:0];
    case (act_q)
      ACT_NEW: begin
        if (match_q) begin
          nxt[match_idx_q] = {qty_sat, nord_sat, price_q};
          app_err = (qsum[QTY_W] || nsum[NORD_W]) ? ERR_SAT : ERR_OK;
          app_lvl = match_idx_q;
        end else if (ins_idx_q < CNT_W'(DEPTH)) begin
          // On a full book, the shift pushes the worst level off the end.
          for (int i = DEPTH - 1; i >= 1; i--) begin
            nxt[i] = (CNT_W'(i) > ins_idx_q) ? cur[i-1] : cur[i];
          end
          nxt[ins_idx_q[IDX_W-1:0]] = {qty_q, nord_q, price_q};
          nxt_cnt = (cur_cnt == CNT_W'(DEPTH)) ? cur_cnt : cur_cnt + CNT_W'(1);
          app_lvl = ins_idx_q[IDX_W-1:0];
        end else begin
          app_err = ERR_DROP;
        end
      end
      ACT_CHG: begin
        if (match_q && qty_q == '0) begin
          do_del = 1'b1;
        end else if (match_q) begin
          nxt[match_idx_q] = {qty_q, nord_q, price_q};
          app_lvl = match_idx_q;
        end else begin
          app_err = ERR_NOMATCH;
        end
      end
      ACT_DEL: begin
        if (match_q) begin
          do_del = 1'b1;
        end else begin
          app_err = ERR_NOMATCH;
        end
      end
      ACT_CLR: begin
        for (int i = 0; i < DEPTH; i++) begin
          nxt[i] = '0;
        end
        nxt_cnt = '0;
      end
      default: begin
        nxt_cnt = cur_cnt;
      end
    endcase
    // Slots past the count are zero, so shifting up also clears the last valid slot.
    if (do_del) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        nxt[i] = (IDX_W'(i) >= match_idx_q) ? cur[i+1] : cur[i];
      end
      nxt[DEPTH-1] = '0;
      nxt_cnt = cur_cnt - CNT_W'(1);
      app_lvl = match_idx_q;
    end else begin
      app_lvl = app_lvl;
    end
  end

  // Sequencer: captures the request, latches the search result, and commits the update.
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    side_d      = side_q;
    price_d     = price_q;
    qty_d       = qty_q;
    nord_d      = nord_q;
    match_d     = match_q;
    match_idx_d = match_idx_q;
    ins_idx_d   = ins_idx_q;
    bid_d       = bid_q;
    ask_d       = ask_q;
    bid_cnt_d   = bid_cnt_q;
    ask_cnt_d   = ask_cnt_q;
    upd_valid_d = 1'b0;
    upd_level_d = upd_level_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          act_d   = in_action;
          side_d  = in_side;
          price_d = in_price;
          qty_d   = in_qty;
          nord_d  = in_norders;
          state_d = ST_SEARCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        match_d     = srch_match;
        match_idx_d = srch_midx;
        ins_idx_d   = srch_ins;
        state_d     = ST_APPLY;
      end
      ST_APPLY: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (side_q) begin
            ask_d[i*LVL_W +: LVL_W] = nxt[i];
          end else begin
            bid_d[i*LVL_W +: LVL_W] = nxt[i];
          end
        end
        if (side_q) begin
          ask_cnt_d = nxt_cnt;
        end else begin
          bid_cnt_d = nxt_cnt;
        end
        upd_valid_d = 1'b1;
        upd_level_d = app_lvl;
        err_d       = app_err;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and book registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      act_q       <= 2'd0;
      side_q      <= 1'b0;
      price_q     <= '0;
      qty_q       <= '0;
      nord_q      <= '0;
      match_q     <= 1'b0;
      match_idx_q <= '0;
      ins_idx_q   <= '0;
      bid_q       <= '0;
      ask_q       <= '0;
      bid_cnt_q   <= '0;
      ask_cnt_q   <= '0;
      upd_valid_q <= 1'b0;
      upd_level_q <= '0;
      err_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      side_q      <= side_d;
      price_q     <= price_d;
      qty_q       <= qty_d;
      nord_q      <= nord_d;
      match_q     <= match_d;
      match_idx_q <= match_idx_d;
      ins_idx_q   <= ins_idx_d;
      bid_q       <= bid_d;
      ask_q       <= ask_d;
      bid_cnt_q   <= bid_cnt_d;
      ask_cnt_q   <= ask_cnt_d;
      upd_valid_q <= upd_valid_d;
      upd_level_q <= upd_level_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign bid_book  = bid_q;
  assign ask_book  = ask_q;
  assign bid_count = bid_cnt_q;
  assign ask_count = ask_cnt_q;
  assign upd_valid = upd_valid_q;
  assign upd_level = upd_level_q;
  assign err       = err_q;

endmodule

// File: tb/tb_price_level_book.sv
// Directed bench for price_level_book with DEPTH=10, PRICE_W=64, QTY_W=16 and NORD_W=8.
// Expected values are hand-computed constants.
module tb_price_level_book;

  localparam int DEPTH = 10;
  localparam int LW    = 16 + 8 + 64;
  localparam int BW    = DEPTH * LW;
  localparam logic [1:0] A_NEW = 2'd0, A_CHG = 2'd1, A_DEL = 2'd2, A_CLR = 2'd3;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, in_side, upd_valid;
  logic [1:0]    in_action, err;
  logic [63:0]   in_price;
  logic [15:0]   in_qty;
  logic [7:0]    in_norders;
  logic [BW-1:0] bid_book, ask_book, bid_snap, ask_snap;
  logic [3:0]    bid_count, ask_count, upd_level;
  int            checks = 0;
  int            failures = 0;

  price_level_book #(.DEPTH(DEPTH), .PRICE_W(64), .QTY_W(16), .NORD_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_action(in_action), .in_side(in_side), .in_price(in_price),
    .in_qty(in_qty), .in_norders(in_norders), .bid_book(bid_book),
    .ask_book(ask_book), .bid_count(bid_count), .ask_count(ask_count),
    .upd_valid(upd_valid), .upd_level(upd_level), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pr(input logic [BW-1:0] b, input int k);
    return b[k*LW +: 64];
  endfunction

  function automatic logic [15:0] qt(input logic [BW-1:0] b, input int k);
    return b[k*LW+72 +: 16];
  endfunction

  function automatic logic [7:0] no(input logic [BW-1:0] b, input int k);
    return b[k*LW+64 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic [1:0] a, input logic s,
                        input logic [63:0] p, input logic [15:0] q, input logic [7:0] n,
                        input logic [1:0] e_err, input logic [3:0] e_lvl);
    int guard;
    guard = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_action = a; in_side = s; in_price = p; in_qty = q; in_norders = n;
    @(posedge clk); #1;
    in_valid = 1'b0; in_action = A_CLR; in_side = ~s; in_price = {$urandom, $urandom};
    chk({tag, "_busy"}, 64'(in_ready), 64'd0);
    chk({tag, "_early1"}, 64'(upd_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_early2"}, 64'(upd_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_upd"}, 64'(upd_valid), 64'd1);
    chk({tag, "_err"}, 64'(err), 64'(e_err));
    chk({tag, "_lvl"}, 64'(upd_level), 64'(e_lvl));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_action = A_NEW; in_side = 1'b0;
    in_price = 64'd0; in_qty = 16'd0; in_norders = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bid_zero", 64'(bid_book == '0), 64'd1);
    chk("rst_ask_zero", 64'(ask_book == '0), 64'd1);
    chk("rst_bid_cnt", 64'(bid_count), 64'd0);
    chk("rst_ask_cnt", 64'(ask_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_upd", 64'(upd_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_lvl", 64'(upd_level), 64'd0);

    // Insertion keeps bids descending.
    do_req("nb100", A_NEW, 1'b0, 64'd100, 16'd5, 8'd1, 2'd0, 4'd0);
    do_req("nb102", A_NEW, 1'b0, 64'd102, 16'd3, 8'd1, 2'd0, 4'd0);
    do_req("nb101", A_NEW, 1'b0, 64'd101, 16'd4, 8'd2, 2'd0, 4'd1);
    chk("b3_p0", pr(bid_book, 0), 64'd102);
    chk("b3_p1", pr(bid_book, 1), 64'd101);
    chk("b3_p2", pr(bid_book, 2), 64'd100);
    chk("b3_p3", pr(bid_book, 3), 64'd0);
    chk("b3_q2", 64'(qt(bid_book, 2)), 64'd5);
    chk("b3_n1", 64'(no(bid_book, 1)), 64'd2);
    chk("b3_cnt", 64'(bid_count), 64'd3);
    chk("b3_ask", 64'(ask_count), 64'd0);

    // Delete with and without a match.
    do_req("del101", A_DEL, 1'b0, 64'd101, 16'd0, 8'd0, 2'd0, 4'd1);
    chk("d_p0", pr(bid_book, 0), 64'd102);
    chk("d_p1", pr(bid_book, 1), 64'd100);
    chk("d_l2", 64'(bid_book[2*LW +: LW] == '0), 64'd1);
    chk("d_cnt", 64'(bid_count), 64'd2);
    bid_snap = bid_book;
    do_req("del99", A_DEL, 1'b0, 64'd99, 16'd0, 8'd0, 2'd1, 4'd0);
    chk("d99_same", 64'(bid_book === bid_snap), 64'd1);
    chk("d99_cnt", 64'(bid_count), 64'd2);

    // Saturation, change overwrite, change miss, and change to zero.
    do_req("nb50a", A_NEW, 1'b0, 64'd50, 16'hFFF0, 8'd1, 2'd0, 4'd2);
    do_req("nb50b", A_NEW, 1'b0, 64'd50, 16'h0020, 8'd1, 2'd3, 4'd2);
    chk("sat_q", 64'(qt(bid_book, 2)), 64'hFFFF);
    chk("sat_n", 64'(no(bid_book, 2)), 64'd2);
    chk("sat_cnt", 64'(bid_count), 64'd3);
    do_req("chg100", A_CHG, 1'b0, 64'd100, 16'd7, 8'd3, 2'd0, 4'd1);
    chk("chg_q", 64'(qt(bid_book, 1)), 64'd7);
    chk("chg_n", 64'(no(bid_book, 1)), 64'd3);
    chk("chg_p", pr(bid_book, 1), 64'd100);
    do_req("chg77", A_CHG, 1'b0, 64'd77, 16'd1, 8'd1, 2'd1, 4'd0);
    do_req("chg50z", A_CHG, 1'b0, 64'd50, 16'd0, 8'd0, 2'd0, 4'd2);
    chk("chz_cnt", 64'(bid_count), 64'd2);
    chk("chz_l2", 64'(bid_book[2*LW +: LW] == '0), 64'd1);

    // Fill the ask side, drop a too-wide price, then push out the worst level.
    bid_snap = bid_book;
    for (int p = 1; p <= 10; p++) begin
      do_req($sformatf("fill%0d", p), A_NEW, 1'b1, 64'(p), 16'(p), 8'd1, 2'd0, 4'(p - 1));
    end
    chk("fill_cnt", 64'(ask_count), 64'd10);
    chk("fill_p0", pr(ask_book, 0), 64'd1);
    chk("fill_p9", pr(ask_book, 9), 64'd10);
    ask_snap = ask_book;
    do_req("na11", A_NEW, 1'b1, 64'd11, 16'd1, 8'd1, 2'd2, 4'd0);
    chk("na11_same", 64'(ask_book === ask_snap), 64'd1);
    chk("na11_cnt", 64'(ask_count), 64'd10);
    do_req("na0", A_NEW, 1'b1, 64'd0, 16'd9, 8'd1, 2'd0, 4'd0);
    chk("na0_p0", pr(ask_book, 0), 64'd0);
    chk("na0_q0", 64'(qt(ask_book, 0)), 64'd9);
    chk("na0_p1", pr(ask_book, 1), 64'd1);
    chk("na0_p9", pr(ask_book, 9), 64'd9);
    chk("na0_cnt", 64'(ask_count), 64'd10);
    chk("ask_bid_same", 64'(bid_book === bid_snap), 64'd1);

    // in_valid held high: one accept every third cycle.
    in_valid = 1'b1; in_action = A_NEW; in_side = 1'b0;
    in_price = 64'd200; in_qty = 16'd1; in_norders = 8'd1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      chk($sformatf("tp_acc%0d", k), 64'(in_ready), (k % 3 == 0) ? 64'd1 : 64'd0);
      @(posedge clk); #1;
      chk($sformatf("tp_upd%0d", k), 64'(upd_valid), (k % 3 == 2) ? 64'd1 : 64'd0);
    end
    in_valid = 1'b0;
    chk("tp_p0", pr(bid_book, 0), 64'd200);
    chk("tp_q0", 64'(qt(bid_book, 0)), 64'd3);
    chk("tp_n0", 64'(no(bid_book, 0)), 64'd3);
    chk("tp_p1", pr(bid_book, 1), 64'd102);
    chk("tp_cnt", 64'(bid_count), 64'd3);

    // Clear the ask side.
    bid_snap = bid_book;
    do_req("clr_ask", A_CLR, 1'b1, 64'd0, 16'd0, 8'd0, 2'd0, 4'd0);
    chk("clr_cnt", 64'(ask_count), 64'd0);
    chk("clr_zero", 64'(ask_book == '0), 64'd1);
    chk("clr_bid", 64'(bid_book === bid_snap), 64'd1);
    chk("clr_bcnt", 64'(bid_count), 64'd3);

    // Fields change while in_valid is low; the design must ignore them.
    in_action = A_CLR; in_side = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("idle_ready", 64'(in_ready), 64'd1);
      chk("idle_upd", 64'(upd_valid), 64'd0);
    end
    chk("idle_bid", 64'(bid_book === bid_snap), 64'd1);

    // Reset right after accept abandons the request.
    @(negedge clk);
    in_valid = 1'b1; in_action = A_NEW; in_side = 1'b0;
    in_price = 64'd55; in_qty = 16'd1; in_norders = 8'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("ra_ready", 64'(in_ready), 64'd1);
    chk("ra_upd", 64'(upd_valid), 64'd0);
    chk("ra_bid", 64'(bid_book == '0), 64'd1);
    chk("ra_ask", 64'(ask_book == '0), 64'd1);
    chk("ra_bcnt", 64'(bid_count), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("ra_noupd", 64'(upd_valid), 64'd0);
    end
    chk("ra_bid_after", 64'(bid_book == '0), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
